// File: rtl/gamma_loader_pkg.sv
// Shared types and constants for the gamma table loader.
package gamma_loader_pkg;

    localparam int GAMMA_ENTRIES = 768;
    localparam int ADDR_W        = 10;

    typedef enum logic [1:0] {
        INIT    = 2'd0,
        IDLE    = 2'd1,
        LOAD    = 2'd2,
        RESTORE = 2'd3
    } gl_state_t;

endpackage

// File: rtl/gamma_wr_seq.sv
// Table write sequencer: address counter plus registered write port,
// used both by the identity ramp and by the host download path.
module gamma_wr_seq
    import gamma_loader_pkg::*;
#(
    parameter int ENTRIES = GAMMA_ENTRIES
) (
    input  logic              clk_sys,
    input  logic              rst_n,
    input  logic              i_clr,
    input  logic              i_wr,
    input  logic [7:0]        i_data,
    output logic [ADDR_W-1:0] o_cnt,
    output logic              o_full,
    output logic              o_wr,
    output logic [ADDR_W-1:0] o_addr,
    output logic [7:0]        o_value
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(ENTRIES - 1);

    logic [ADDR_W-1:0] r_cnt;
    logic              r_full;
    logic              r_wr;
    logic [ADDR_W-1:0] r_addr;
    logic [7:0]        r_value;

    // The counter parks on the last address and raises r_full instead of wrapping.
    always_ff @(posedge clk_sys) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_full  <= 1'b0;
            r_wr    <= 1'b0;
            r_addr  <= '0;
            r_value <= '0;
        end else begin
            r_wr <= i_wr;
            if (i_wr) begin
                r_addr  <= r_cnt;
                r_value <= i_data;
            end
            if (i_clr) begin
                r_cnt  <= '0;
                r_full <= 1'b0;
            end else if (i_wr) begin
                if (r_cnt == LAST) r_full <= 1'b1;
                else               r_cnt  <= r_cnt + 1'b1;
            end
        end
    end

    assign o_cnt   = r_cnt;
    assign o_full  = r_full;
    assign o_wr    = r_wr;
    assign o_addr  = r_addr;
    assign o_value = r_value;

endmodule

// File: rtl/gamma_loader.sv
// Gamma curve loader: identity ramp after reset/failed load, host download otherwise.
// Optional trailing checksum byte enabled by defining GAMMA_LOADER_CHECKSUM_EN.
module gamma_loader
    import gamma_loader_pkg::*;
#(
    parameter int ENTRIES = GAMMA_ENTRIES
) (
    input  logic              clk_sys,
    input  logic              rst_n,
    input  logic              load_start,
    input  logic              load_end,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    input  logic              gamma_en_req,
    output logic              gamma_en,
    output logic              gamma_wr,
    output logic [ADDR_W-1:0] gamma_wr_addr,
    output logic [7:0]        gamma_value,
    output logic              busy,
    output logic              err
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(ENTRIES - 1);

    gl_state_t r_state;
    logic      r_ready;
    logic      r_busy;
    logic      r_err;
    logic      r_cv;
    logic      r_en;

    logic [ADDR_W-1:0] w_cnt;
    logic              w_full;
    logic              w_in_load;
    logic              w_ramp;
    logic              w_accept;
    logic              w_restart;
    logic              w_data_beat;
    logic              w_seq_wr;
    logic              w_seq_clr;
    logic [7:0]        w_seq_data;
    logic              w_end_ok;
    logic              w_ready_drop;

    assign w_in_load   = (r_state == LOAD);
    assign w_ramp      = (r_state == INIT) || (r_state == RESTORE);
    assign w_accept    = in_valid && r_ready;
    assign w_restart   = load_start && ((r_state == IDLE) || w_in_load);
    // A restart pulse wins over a beat offered in the same cycle.
    assign w_data_beat = w_accept && !w_full && !load_start;
    assign w_seq_wr    = w_ramp || w_data_beat;
    assign w_seq_data  = w_ramp ? w_cnt[7:0] : in_data;
    assign w_seq_clr   = w_restart || (w_in_load && load_end);

`ifdef GAMMA_LOADER_CHECKSUM_EN
    logic       w_ck_beat;
    logic [7:0] r_sum;
    logic [7:0] r_ck;
    logic       r_have_ck;

    assign w_ck_beat = w_accept && w_full && !load_start;

    always_ff @(posedge clk_sys) begin
        if (!rst_n) begin
            r_sum     <= '0;
            r_ck      <= '0;
            r_have_ck <= 1'b0;
        end else if (w_restart) begin
            r_sum     <= '0;
            r_have_ck <= 1'b0;
        end else if (w_data_beat) begin
            r_sum <= r_sum + in_data;
        end else if (w_ck_beat) begin
            r_ck      <= in_data;
            r_have_ck <= 1'b1;
        end
    end

    // The checksum byte may arrive in the same cycle as load_end.
    assign w_end_ok     = (r_have_ck && (r_ck == r_sum)) || (w_ck_beat && (in_data == r_sum));
    assign w_ready_drop = w_ck_beat;
`else
    logic w_last;

    assign w_last       = (w_cnt == LAST) && !w_full;
    assign w_end_ok     = w_full || (w_data_beat && w_last);
    assign w_ready_drop = w_data_beat && w_last;
`endif

    always_ff @(posedge clk_sys) begin
        if (!rst_n) begin
            r_state <= INIT;
            r_ready <= 1'b0;
            r_busy  <= 1'b1;
            r_err   <= 1'b0;
            r_cv    <= 1'b0;
            r_en    <= 1'b0;
        end else begin
            r_en <= gamma_en_req && r_cv && !r_busy;
            case (r_state)
                INIT, RESTORE: begin
                    if (w_cnt == LAST) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                IDLE: begin
                    if (load_start) begin
                        r_state <= LOAD;
                        r_busy  <= 1'b1;
                        r_ready <= 1'b1;
                        r_err   <= 1'b0;
                        r_cv    <= 1'b0;
                    end
                end
                LOAD: begin
                    if (load_start) begin
                        r_ready <= 1'b1;
                        r_err   <= 1'b0;
                        r_cv    <= 1'b0;
                    end else if (load_end) begin
                        r_ready <= 1'b0;
                        if (w_end_ok) begin
                            r_cv    <= 1'b1;
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_err   <= 1'b1;
                            r_cv    <= 1'b0;
                            r_state <= RESTORE;
                        end
                    end else if (w_ready_drop) begin
                        r_ready <= 1'b0;
                    end
                end
                default: begin
                    r_state <= INIT;
                    r_busy  <= 1'b1;
                    r_ready <= 1'b0;
                end
            endcase
        end
    end

    gamma_wr_seq #(
        .ENTRIES (ENTRIES)
    ) u_wr_seq (
        .clk_sys (clk_sys),
        .rst_n   (rst_n),
        .i_clr   (w_seq_clr),
        .i_wr    (w_seq_wr),
        .i_data  (w_seq_data),
        .o_cnt   (w_cnt),
        .o_full  (w_full),
        .o_wr    (gamma_wr),
        .o_addr  (gamma_wr_addr),
        .o_value (gamma_value)
    );

    assign in_ready = r_ready;
    assign busy     = r_busy;
    assign err      = r_err;
    assign gamma_en = r_en;

endmodule

// File: tb/tb_gamma_loader.sv
// Directed bench for gamma_loader: ramp, full/short/restarted loads, mid-load reset,
// and the GAMMA_LOADER_CHECKSUM_EN checksum variants when that macro is defined.
module tb_gamma_loader;

    localparam int ENT = 768;

    logic       clk_sys = 1'b0;
    logic       rst_n;
    logic       load_start;
    logic       load_end;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       gamma_en_req;
    logic       gamma_en;
    logic       gamma_wr;
    logic [9:0] gamma_wr_addr;
    logic [7:0] gamma_value;
    logic       busy;
    logic       err;

    int         n_checks = 0;
    int         n_err    = 0;
    int         exp_addr = 0;
    logic       pend     = 1'b0;
    logic [9:0] pend_addr = '0;
    logic [7:0] pend_data = '0;
`ifdef GAMMA_LOADER_CHECKSUM_EN
    logic [7:0] ck_byte = 8'h00;
`endif

    gamma_loader dut (
        .clk_sys       (clk_sys),
        .rst_n         (rst_n),
        .load_start    (load_start),
        .load_end      (load_end),
        .in_valid      (in_valid),
        .in_data       (in_data),
        .in_ready      (in_ready),
        .gamma_en_req  (gamma_en_req),
        .gamma_en      (gamma_en),
        .gamma_wr      (gamma_wr),
        .gamma_wr_addr (gamma_wr_addr),
        .gamma_value   (gamma_value),
        .busy          (busy),
        .err           (err)
    );

    always #5 clk_sys = ~clk_sys;

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle of host traffic; checks the write owed by the previous beat.
    task automatic cycle(input logic v, input logic [7:0] d, input logic exp_rdy, input logic exp_wr);
        logic nxt;
        in_valid = v;
        in_data  = d;
        @(negedge clk_sys);
        chk("in_ready", in_ready, exp_rdy);
        chk("wr", gamma_wr, pend);
        if (pend) begin
            chk("wr_addr", gamma_wr_addr, pend_addr);
            chk("wr_value", gamma_value, pend_data);
        end
        nxt = v & exp_rdy & exp_wr;
        @(posedge clk_sys); #1;
        pend      = nxt;
        pend_addr = 10'(exp_addr);
        pend_data = d;
        if (nxt) exp_addr++;
        in_valid = 1'b0;
    endtask

    task automatic tick();
        in_valid = 1'b0;
        @(posedge clk_sys); #1;
    endtask

    task automatic pulse_start();
        load_start = 1'b1;
        in_valid   = 1'b0;
        @(posedge clk_sys); #1;
        load_start = 1'b0;
        exp_addr   = 0;
        pend       = 1'b0;
    endtask

    task automatic send_bytes(input int n, input bit ones, input int gap);
        logic [7:0] d;
        for (int b = 0; b < n; b++) begin
            if (gap != 0 && (b % gap) == gap - 1) cycle(1'b0, 8'h00, 1'b1, 1'b1);
            d = ones ? 8'h01 : 8'(255 - (exp_addr & 255));
            cycle(1'b1, d, 1'b1, 1'b1);
        end
    endtask

    // After a complete data phase: optional checksum, a refused extra byte, then load_end.
    task automatic finish_load();
`ifdef GAMMA_LOADER_CHECKSUM_EN
        cycle(1'b1, ck_byte, 1'b1, 1'b0);
`endif
        cycle(1'b1, 8'h5A, 1'b0, 1'b0);
        load_end = 1'b1;
        cycle(1'b0, 8'h00, 1'b0, 1'b0);
        load_end = 1'b0;
    endtask

    task automatic expect_idle_en(input string tag);
        @(negedge clk_sys);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_err"}, err, 1'b0);
        chk({tag, "_en_lat"}, gamma_en, 1'b0);
        @(posedge clk_sys); #1;
        @(negedge clk_sys);
        chk({tag, "_en"}, gamma_en, 1'b1);
        @(posedge clk_sys); #1;
    endtask

    task automatic check_ramp(input string tag);
        int w = 0;
        pend = 1'b0;
        @(negedge clk_sys);
        while (gamma_wr !== 1'b1 && w < 8) begin
            @(negedge clk_sys);
            w++;
        end
        chk({tag, "_start"}, gamma_wr, 1'b1);
        if (gamma_wr === 1'b1) begin
            for (int i = 0; i < ENT; i++) begin
                if (i > 0) @(negedge clk_sys);
                chk({tag, "_wr"}, gamma_wr, 1'b1);
                chk({tag, "_addr"}, gamma_wr_addr, i);
                chk({tag, "_value"}, gamma_value, i & 255);
                chk({tag, "_en"}, gamma_en, 1'b0);
                if (i < ENT - 1) chk({tag, "_busy"}, busy, 1'b1);
            end
            @(negedge clk_sys);
            chk({tag, "_wr_end"}, gamma_wr, 1'b0);
            chk({tag, "_busy_end"}, busy, 1'b0);
        end
        @(posedge clk_sys); #1;
    endtask

    task automatic expect_restore(input string tag);
        @(negedge clk_sys);
        chk({tag, "_err"}, err, 1'b1);
        chk({tag, "_busy"}, busy, 1'b1);
        @(posedge clk_sys); #1;
        check_ramp({tag, "_ramp"});
        chk({tag, "_err_kept"}, err, 1'b1);
        tick();
        tick();
        chk({tag, "_en_after"}, gamma_en, 1'b0);
    endtask

    initial begin
        rst_n        = 1'b0;
        load_start   = 1'b0;
        load_end     = 1'b0;
        in_valid     = 1'b0;
        in_data      = 8'h00;
        gamma_en_req = 1'b1;

        // Reset state
        repeat (3) @(posedge clk_sys);
        @(negedge clk_sys);
        chk("rst_wr", gamma_wr, 1'b0);
        chk("rst_addr", gamma_wr_addr, 0);
        chk("rst_value", gamma_value, 0);
        chk("rst_en", gamma_en, 1'b0);
        chk("rst_ready", in_ready, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_busy", busy, 1'b1);
        @(posedge clk_sys); #1;
        rst_n = 1'b1;

        check_ramp("init");

        // IDLE ignores host bytes and load_end
        load_end = 1'b1;
        cycle(1'b1, 8'h33, 1'b0, 1'b0);
        load_end = 1'b0;
        cycle(1'b0, 8'h00, 1'b0, 1'b0);
        chk("idle_busy", busy, 1'b0);
        chk("idle_en", gamma_en, 1'b0);

        // Full download with gaps
`ifdef GAMMA_LOADER_CHECKSUM_EN
        ck_byte = 8'h80;
`endif
        pulse_start();
        chk("load_busy", busy, 1'b1);
        send_bytes(ENT, 1'b0, 5);
        finish_load();
        expect_idle_en("full");
        gamma_en_req = 1'b0;
        tick();
        tick();
        chk("en_req_off", gamma_en, 1'b0);
        gamma_en_req = 1'b1;
        tick();
        tick();
        chk("en_req_on", gamma_en, 1'b1);

        // Short download
        pulse_start();
        send_bytes(100, 1'b0, 0);
        load_end = 1'b1;
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        load_end = 1'b0;
        expect_restore("short");

        // Restart after 300 bytes
        pulse_start();
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        chk("restart_err_clr", err, 1'b0);
        send_bytes(300, 1'b0, 7);
        pulse_start();
        send_bytes(ENT, 1'b0, 0);
        finish_load();
        expect_idle_en("restart");

        // Reset pulse during download at byte 500
        pulse_start();
        send_bytes(500, 1'b0, 0);
        rst_n = 1'b0;
        @(posedge clk_sys); #1;
        rst_n = 1'b1;
        check_ramp("midrst");
        chk("midrst_err", err, 1'b0);
        chk("midrst_en", gamma_en, 1'b0);

`ifdef GAMMA_LOADER_CHECKSUM_EN
        // Good checksum: 768 x 0x01 sums to 0x00
        ck_byte = 8'h00;
        pulse_start();
        send_bytes(ENT, 1'b1, 0);
        finish_load();
        expect_idle_en("ck_good");

        // Bad checksum
        pulse_start();
        send_bytes(ENT, 1'b1, 0);
        cycle(1'b1, 8'h01, 1'b1, 1'b0);
        load_end = 1'b1;
        cycle(1'b0, 8'h00, 1'b0, 1'b0);
        load_end = 1'b0;
        expect_restore("ck_bad");
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
